regwb_arbiter: RTL and testbench

REGWB_ARBITER -- requirements
Module: regwb_arbiter

---
 rtl/regwb_pkg.sv | 14 +
 rtl/regwb_scoreboard.sv | 53 +++++
 rtl/regwb_arbiter.sv | 147 ++++++++++++++
 tb/tb_regwb_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/regwb_pkg.sv
// Shared widths and write-source encoding for the register writeback arbiter.
package regwb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_PIPE = 2'd1,
    WB_LLU  = 2'd2
  } wb_src_e;

endpackage

// File: rtl/regwb_scoreboard.sv
// Pending-destination bitmap for long-latency ops and the decode hazard check.
module regwb_scoreboard
  import regwb_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_rd,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_rd,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  output logic [NUM_REGS-1:0]   pending,
  output logic                  hazard
);

  logic [NUM_REGS-1:0] pending_reg;
  wire  [NUM_REGS-1:0] pending_next;
  wire  [NUM_REGS-1:0] fwd_mask;
  logic [NUM_REGS-1:0] pending_vis;

  // x0 is never tracked, so it can never raise a hazard.
  assign pending_next[0] = 1'b0;
  assign fwd_mask[0]     = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_bit
      // A new issue beats the retiring write to the same register.
      assign pending_next[gi] = (set_en && (set_rd == REG_ADDR_W'(gi))) ||
                                (pending_reg[gi] && !(wr_en && (wr_rd == REG_ADDR_W'(gi))));
      assign fwd_mask[gi]     = wr_en && (wr_rd == REG_ADDR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  // The register being written this cycle is forwarded by the register file.
  always_comb begin
    pending_vis = pending_reg & ~fwd_mask;
    hazard      = pending_vis[rs1_addr] | pending_vis[rs2_addr] | pending_vis[rd_addr];
  end

  assign pending = pending_reg;

endmodule

// File: rtl/regwb_arbiter.sv
// Register-file write port arbiter between the pipeline and a buffered LLU result.
// Optional starvation guard: define REGWB_STARVE_GUARD_EN.
module regwb_arbiter
  import regwb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wb_we_i,
  input  logic [REG_ADDR_W-1:0] wb_addr_i,
  input  logic [XLEN-1:0]       wb_data_i,
  input  logic                  llu_issue_i,
  input  logic [REG_ADDR_W-1:0] llu_issue_rd_i,
  input  logic                  llu_valid_i,
  input  logic [REG_ADDR_W-1:0] llu_rd_i,
  input  logic [XLEN-1:0]       llu_data_i,
  output logic                  llu_ready_o,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  output logic                  hazard_o,
  output logic                  stall_o,
  output logic                  RegWrite_o,
  output logic [REG_ADDR_W-1:0] RDaddr_o,
  output logic [XLEN-1:0]       RDdata_o,
  output logic [NUM_REGS-1:0]   pending_o
);

  logic                  buf_valid_reg, buf_valid_next;
  logic [REG_ADDR_W-1:0] buf_rd_reg,    buf_rd_next;
  logic [XLEN-1:0]       buf_data_reg,  buf_data_next;

  wb_src_e wb_src;
  logic    pipe_req;
  logic    force_slot;
  logic    buf_grant;
  logic    llu_accept;

  assign pipe_req = wb_we_i && (wb_addr_i != '0);

  always_comb begin
    wb_src = WB_NONE;
    if (pipe_req && !force_slot) begin
      wb_src = WB_PIPE;
    end else if (buf_valid_reg) begin
      wb_src = WB_LLU;
    end
  end

  assign buf_grant   = (wb_src == WB_LLU);
  assign llu_ready_o = !buf_valid_reg || buf_grant;
  assign llu_accept  = llu_valid_i && llu_ready_o;

  // Held at zero during reset even if the pipeline is still requesting.
  always_comb begin
    RegWrite_o = 1'b0;
    RDaddr_o   = '0;
    RDdata_o   = '0;
    if (rst_ni) begin
      case (wb_src)
        WB_PIPE: begin
          RegWrite_o = 1'b1;
          RDaddr_o   = wb_addr_i;
          RDdata_o   = wb_data_i;
        end
        WB_LLU: begin
          RegWrite_o = 1'b1;
          RDaddr_o   = buf_rd_reg;
          RDdata_o   = buf_data_reg;
        end
        default: ;
      endcase
    end
  end

  // Results for x0 are accepted but dropped on the floor.
  always_comb begin
    buf_valid_next = buf_valid_reg;
    buf_rd_next    = buf_rd_reg;
    buf_data_next  = buf_data_reg;
    if (llu_accept && (llu_rd_i != '0)) begin
      buf_valid_next = 1'b1;
      buf_rd_next    = llu_rd_i;
      buf_data_next  = llu_data_i;
    end else if (buf_grant) begin
      buf_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_valid_reg <= 1'b0;
      buf_rd_reg    <= '0;
      buf_data_reg  <= '0;
    end else begin
      buf_valid_reg <= buf_valid_next;
      buf_rd_reg    <= buf_rd_next;
      buf_data_reg  <= buf_data_next;
    end
  end

`ifdef REGWB_STARVE_GUARD_EN
  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (buf_grant) begin
      starve_cnt_next = '0;
    end else if (buf_valid_reg && (starve_cnt_reg != CNT_W'(STARVE_LIMIT))) begin
      starve_cnt_next = starve_cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_cnt_reg <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  assign force_slot = buf_valid_reg && (starve_cnt_reg == CNT_W'(STARVE_LIMIT));
  assign stall_o    = force_slot && pipe_req;
`else
  // The limit only matters when the guard is built in.
  assign force_slot = 1'b0 && (STARVE_LIMIT != 0);
  assign stall_o    = 1'b0;
`endif

  regwb_scoreboard u_scoreboard (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .set_en   (llu_issue_i),
    .set_rd   (llu_issue_rd_i),
    .wr_en    (buf_grant),
    .wr_rd    (buf_rd_reg),
    .rs1_addr (rs1_addr_i),
    .rs2_addr (rs2_addr_i),
    .rd_addr  (rd_addr_i),
    .pending  (pending_o),
    .hazard   (hazard_o)
  );

endmodule

// File: tb/tb_regwb_arbiter.sv
// Directed bench for regwb_arbiter; expectations are hand-computed per cycle.
module tb_regwb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        wb_we_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic        llu_issue_i;
  logic [4:0]  llu_issue_rd_i;
  logic        llu_valid_i;
  logic [4:0]  llu_rd_i;
  logic [31:0] llu_data_i;
  logic        llu_ready_o;
  logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic        hazard_o, stall_o, RegWrite_o;
  logic [4:0]  RDaddr_o;
  logic [31:0] RDdata_o;
  logic [31:0] pending_o;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk_i = ~clk_i;

  regwb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .wb_we_i        (wb_we_i),
    .wb_addr_i      (wb_addr_i),
    .wb_data_i      (wb_data_i),
    .llu_issue_i    (llu_issue_i),
    .llu_issue_rd_i (llu_issue_rd_i),
    .llu_valid_i    (llu_valid_i),
    .llu_rd_i       (llu_rd_i),
    .llu_data_i     (llu_data_i),
    .llu_ready_o    (llu_ready_o),
    .rs1_addr_i     (rs1_addr_i),
    .rs2_addr_i     (rs2_addr_i),
    .rd_addr_i      (rd_addr_i),
    .hazard_o       (hazard_o),
    .stall_o        (stall_o),
    .RegWrite_o     (RegWrite_o),
    .RDaddr_o       (RDaddr_o),
    .RDdata_o       (RDdata_o),
    .pending_o      (pending_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven and
  // outputs checked #1 later, well before the falling edge.
  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    wb_we_i = 1'b1; wb_addr_i = 5'd3; wb_data_i = 32'h33;
    llu_issue_i = 1'b0; llu_issue_rd_i = '0;
    llu_valid_i = 1'b0; llu_rd_i = '0; llu_data_i = '0;
    rs1_addr_i = '0; rs2_addr_i = '0; rd_addr_i = '0;
    #2;
    check("rst_pending", pending_o, 32'h0);
    check("rst_regwrite_gated", {31'b0, RegWrite_o}, 32'h0);
    check("rst_hazard", {31'b0, hazard_o}, 32'h0);
    check("rst_stall", {31'b0, stall_o}, 32'h0);
    check("rst_ready", {31'b0, llu_ready_o}, 32'h1);

    next_cycle();
    next_cycle();
    rst_ni = 1'b1; wb_we_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;

    // Issue x5, decode reads x5 in the same cycle: not yet visible.
    next_cycle();
    llu_issue_i = 1'b1; llu_issue_rd_i = 5'd5; rs1_addr_i = 5'd5;
    #1 check("a_hazard_same_cycle", {31'b0, hazard_o}, 32'h0);
    next_cycle();
    llu_issue_i = 1'b0;
    #1 check("a_hazard_pending", {31'b0, hazard_o}, 32'h1);
    check("a_pending_x5", pending_o, 32'h0000_0020);
    next_cycle();
    llu_valid_i = 1'b1; llu_rd_i = 5'd5; llu_data_i = 32'h1234_5678;
    #1 check("a_ready_empty", {31'b0, llu_ready_o}, 32'h1);
    check("a_no_write_on_accept", {31'b0, RegWrite_o}, 32'h0);
    check("a_hazard_until_write", {31'b0, hazard_o}, 32'h1);
    next_cycle();
    llu_valid_i = 1'b0;
    #1 check("a_buf_write", {31'b0, RegWrite_o}, 32'h1);
    check("a_buf_addr", {27'b0, RDaddr_o}, 32'd5);
    check("a_buf_data", RDdata_o, 32'h1234_5678);
    check("a_hazard_masked", {31'b0, hazard_o}, 32'h0);
    next_cycle();
    rs1_addr_i = '0;
    #1 check("a_pending_cleared", pending_o, 32'h0);
    check("a_idle_write", {31'b0, RegWrite_o}, 32'h0);
    check("a_idle_data", RDdata_o, 32'h0);

    // LLU result rd=7 with no pipeline traffic.
    next_cycle();
    llu_issue_i = 1'b1; llu_issue_rd_i = 5'd7;
    next_cycle();
    llu_issue_i = 1'b0;
    llu_valid_i = 1'b1; llu_rd_i = 5'd7; llu_data_i = 32'hDEAD_BEEF;
    #1 check("b_pending_x7", pending_o, 32'h0000_0080);
    check("b_no_write_yet", {31'b0, RegWrite_o}, 32'h0);
    next_cycle();
    llu_valid_i = 1'b0;
    #1 check("b_write", {31'b0, RegWrite_o}, 32'h1);
    check("b_addr", {27'b0, RDaddr_o}, 32'd7);
    check("b_data", RDdata_o, 32'hDEAD_BEEF);
    next_cycle();
    #1 check("b_pending_cleared", pending_o, 32'h0);

    // Result for x0 is swallowed.
    next_cycle();
    llu_valid_i = 1'b1; llu_rd_i = 5'd0; llu_data_i = 32'h55;
    #1 check("c_ready_rd0", {31'b0, llu_ready_o}, 32'h1);
    next_cycle();
    llu_valid_i = 1'b0;
    #1 check("c_no_write", {31'b0, RegWrite_o}, 32'h0);
    check("c_ready_after", {31'b0, llu_ready_o}, 32'h1);

    // Plain pipeline writes, including to x0.
    next_cycle();
    wb_we_i = 1'b1; wb_addr_i = 5'd3; wb_data_i = 32'hA5;
    #1 check("p_write", {31'b0, RegWrite_o}, 32'h1);
    check("p_addr", {27'b0, RDaddr_o}, 32'd3);
    check("p_data", RDdata_o, 32'hA5);
    next_cycle();
    wb_addr_i = 5'd0; wb_data_i = 32'hFF;
    #1 check("p_x0_no_write", {31'b0, RegWrite_o}, 32'h0);
    check("p_x0_data_zero", RDdata_o, 32'h0);

    // Continuous pipeline traffic with a buffered result for x9.
    next_cycle();
    wb_addr_i = 5'd2; wb_data_i = 32'h22;
    llu_issue_i = 1'b1; llu_issue_rd_i = 5'd9;
    next_cycle();
    llu_issue_i = 1'b0;
    llu_valid_i = 1'b1; llu_rd_i = 5'd9; llu_data_i = 32'h99; rd_addr_i = 5'd9;
    #1 check("d_ready_c0", {31'b0, llu_ready_o}, 32'h1);
    check("d_hazard_rd", {31'b0, hazard_o}, 32'h1);
    check("d_addr_c0", {27'b0, RDaddr_o}, 32'd2);
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      llu_valid_i = 1'b0;
      #1 check($sformatf("d_addr_c%0d", k), {27'b0, RDaddr_o}, 32'd2);
      check($sformatf("d_stall_c%0d", k), {31'b0, stall_o}, 32'h0);
      check($sformatf("d_ready_c%0d", k), {31'b0, llu_ready_o}, 32'h0);
    end
    next_cycle();
`ifdef REGWB_STARVE_GUARD_EN
    #1 check("d_forced_addr", {27'b0, RDaddr_o}, 32'd9);
    check("d_forced_data", RDdata_o, 32'h99);
    check("d_forced_stall", {31'b0, stall_o}, 32'h1);
    check("d_forced_ready", {31'b0, llu_ready_o}, 32'h1);
    check("d_forced_hazard", {31'b0, hazard_o}, 32'h0);
`else
    #1 check("d_c5_addr", {27'b0, RDaddr_o}, 32'd2);
    check("d_c5_stall", {31'b0, stall_o}, 32'h0);
    check("d_c5_ready", {31'b0, llu_ready_o}, 32'h0);
    check("d_c5_hazard", {31'b0, hazard_o}, 32'h1);
`endif
    next_cycle();
    wb_we_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
`ifdef REGWB_STARVE_GUARD_EN
    #1 check("d_after_write", {31'b0, RegWrite_o}, 32'h0);
`else
    #1 check("d_drain_write", {31'b0, RegWrite_o}, 32'h1);
    check("d_drain_addr", {27'b0, RDaddr_o}, 32'd9);
    check("d_drain_data", RDdata_o, 32'h99);
`endif
    next_cycle();
    #1 check("d_pending_cleared", pending_o, 32'h0);
    check("d_hazard_cleared", {31'b0, hazard_o}, 32'h0);
    rd_addr_i = '0;

    // Reset in the middle of a held buffer with x5 and x9 pending.
    next_cycle();
    wb_we_i = 1'b1; wb_addr_i = 5'd4; wb_data_i = 32'h44;
    llu_issue_i = 1'b1; llu_issue_rd_i = 5'd5;
    next_cycle();
    llu_issue_rd_i = 5'd9;
    llu_valid_i = 1'b1; llu_rd_i = 5'd5; llu_data_i = 32'h55;
    next_cycle();
    llu_issue_i = 1'b0; llu_valid_i = 1'b0; rs1_addr_i = 5'd9;
    #1 check("e_pending_pre", pending_o, 32'h0000_0220);
    check("e_ready_full", {31'b0, llu_ready_o}, 32'h0);
    #1 rst_ni = 1'b0;
    #1 check("e_rst_pending", pending_o, 32'h0);
    check("e_rst_write", {31'b0, RegWrite_o}, 32'h0);
    check("e_rst_ready", {31'b0, llu_ready_o}, 32'h1);
    check("e_rst_hazard", {31'b0, hazard_o}, 32'h0);
    next_cycle();
    next_cycle();
    rst_ni = 1'b1; wb_we_i = 1'b0; wb_addr_i = '0; wb_data_i = '0; rs1_addr_i = '0;
    #1 check("e_post_write0", {31'b0, RegWrite_o}, 32'h0);
    next_cycle();
    #1 check("e_post_write1", {31'b0, RegWrite_o}, 32'h0);
    check("e_post_pending", pending_o, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
